// File: rtl/mem_port_arbiter_pkg.sv
// ============================================================================
// Module  : mem_port_arbiter_pkg
// Brief   : Shared encodings for the unified-memory port arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_port_arbiter_pkg;

  localparam int DEF_AW = 12;

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } arb_state_e;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_IF   = 2'd1,
    TAG_DM   = 2'd2
  } resp_tag_e;

  // Only reads produce a response; stores and idle cycles carry no tag.
  function automatic resp_tag_e grant_tag_of(input logic if_gnt, input logic dm_gnt,
                                             input logic dm_we);
    resp_tag_e tag;
    tag = TAG_NONE;
    if (dm_gnt && !dm_we) begin
      tag = TAG_DM;
    end else if (if_gnt) begin
      tag = TAG_IF;
    end
    return tag;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_resp_route.sv
// ============================================================================
// Module  : arb_resp_route
// Brief   : Registers the read-response tag and steers RAM read data to the
//           fetch or data port; each rdata output holds its last value.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module arb_resp_route
  import mem_port_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  resp_tag_e   grant_tag,
  input  logic [31:0] mem_rdata,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        dm_rvalid,
  output logic [31:0] dm_rdata
);

  resp_tag_e   tag_q, tag_d;
  logic [31:0] if_hold_q, if_hold_d;
  logic [31:0] dm_hold_q, dm_hold_d;

  always_comb begin
    tag_d     = grant_tag;
    // A response whose cycle coincides with reset is dropped.
    if_rvalid = (tag_q == TAG_IF) && !reset;
    dm_rvalid = (tag_q == TAG_DM) && !reset;
    if_rdata  = if_rvalid ? mem_rdata : if_hold_q;
    dm_rdata  = dm_rvalid ? mem_rdata : dm_hold_q;
    if_hold_d = if_rdata;
    dm_hold_d = dm_rdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tag_q     <= TAG_NONE;
      if_hold_q <= '0;
      dm_hold_q <= '0;
    end else begin
      tag_q     <= tag_d;
      if_hold_q <= if_hold_d;
      dm_hold_q <= dm_hold_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module  : mem_port_arbiter
// Brief   : Shares one single-port word RAM between the boot loader, the core
//           data port and the core fetch port. Optional performance counters
//           are built when ARB_PERF_CNT_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW       = DEF_AW,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          boot_done,
  input  logic          ld_req,
  input  logic [AW-1:0] ld_addr,
  input  logic [31:0]   ld_wdata,
  output logic          ld_gnt,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [31:0]   if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [3:0]    dm_be,
  input  logic [AW-1:0] dm_addr,
  input  logic [31:0]   dm_wdata,
  output logic          dm_gnt,
  output logic          dm_rvalid,
  output logic [31:0]   dm_rdata,
  output logic          mem_en,
  output logic [3:0]    mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output logic          core_stall,
  output logic          in_boot
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]   perf_if_stall,
  output logic [31:0]   perf_dm_grant
`endif
);

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  arb_state_e state_q, state_d;
  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic       if_win;
  resp_tag_e  grant_tag;

  always_comb begin
    state_d    = state_q;
    ld_gnt     = 1'b0;
    if_gnt     = 1'b0;
    dm_gnt     = 1'b0;
    if_win     = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 4'h0;
    mem_addr   = '0;
    mem_wdata  = '0;
    core_stall = 1'b1;
    in_boot    = (state_q == ST_BOOT) || reset;

    if (!reset) begin
      case (state_q)
        ST_BOOT: begin
          ld_gnt = ld_req;
          if (ld_req) begin
            mem_en    = 1'b1;
            mem_we    = 4'hF;
            mem_addr  = ld_addr;
            mem_wdata = ld_wdata;
          end
          if (boot_done) begin
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          // Data wins by default; a fetch that has waited MAX_WAIT cycles is promoted.
          if_win = if_req && (!dm_req || (wait_cnt_q == MAX_WAIT_C));
          if_gnt = if_win;
          dm_gnt = dm_req && !if_win;
          if (dm_gnt) begin
            mem_en    = 1'b1;
            mem_we    = dm_we ? dm_be : 4'h0;
            mem_addr  = dm_addr;
            mem_wdata = dm_wdata;
          end else if (if_gnt) begin
            mem_en   = 1'b1;
            mem_addr = if_addr;
          end
          core_stall = (if_req && !if_gnt) || (dm_req && !dm_gnt);
        end
        default: state_d = ST_BOOT;
      endcase
    end

    grant_tag = grant_tag_of(if_gnt, dm_gnt, dm_we);

    if (if_req && !if_gnt) begin
      wait_cnt_d = (wait_cnt_q == MAX_WAIT_C) ? wait_cnt_q : wait_cnt_q + 4'd1;
    end else begin
      wait_cnt_d = 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_BOOT;
      wait_cnt_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  arb_resp_route u_resp_route (
    .clk       (clk),
    .reset     (reset),
    .grant_tag (grant_tag),
    .mem_rdata (mem_rdata),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .dm_rvalid (dm_rvalid),
    .dm_rdata  (dm_rdata)
  );

`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_if_stall_q, perf_if_stall_d;
  logic [31:0] perf_dm_grant_q, perf_dm_grant_d;

  always_comb begin
    perf_if_stall_d = perf_if_stall_q;
    perf_dm_grant_d = perf_dm_grant_q;
    if ((state_q == ST_RUN) && if_req && !if_gnt) begin
      perf_if_stall_d = perf_if_stall_q + 32'd1;
    end
    if (dm_gnt) begin
      perf_dm_grant_d = perf_dm_grant_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_if_stall_q <= '0;
      perf_dm_grant_q <= '0;
    end else begin
      perf_if_stall_q <= perf_if_stall_d;
      perf_dm_grant_q <= perf_dm_grant_d;
    end
  end

  assign perf_if_stall = perf_if_stall_q;
  assign perf_dm_grant = perf_dm_grant_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module  : tb_mem_port_arbiter
// Brief   : Directed self-checking bench for mem_port_arbiter with a word RAM
//           model whose unwritten words read back as 32'hA5000000 | address.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic          boot_done;
  logic          ld_req;
  logic [AW-1:0] ld_addr;
  logic [31:0]   ld_wdata;
  logic          ld_gnt;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [31:0]   if_rdata;
  logic          dm_req;
  logic          dm_we;
  logic [3:0]    dm_be;
  logic [AW-1:0] dm_addr;
  logic [31:0]   dm_wdata;
  logic          dm_gnt;
  logic          dm_rvalid;
  logic [31:0]   dm_rdata;
  logic          mem_en;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic          core_stall;
  logic          in_boot;
`ifdef ARB_PERF_CNT_EN
  logic [31:0]   perf_if_stall;
  logic [31:0]   perf_dm_grant;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .MAX_WAIT(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .boot_done  (boot_done),
    .ld_req     (ld_req),
    .ld_addr    (ld_addr),
    .ld_wdata   (ld_wdata),
    .ld_gnt     (ld_gnt),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_gnt     (if_gnt),
    .if_rvalid  (if_rvalid),
    .if_rdata   (if_rdata),
    .dm_req     (dm_req),
    .dm_we      (dm_we),
    .dm_be      (dm_be),
    .dm_addr    (dm_addr),
    .dm_wdata   (dm_wdata),
    .dm_gnt     (dm_gnt),
    .dm_rvalid  (dm_rvalid),
    .dm_rdata   (dm_rdata),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .core_stall (core_stall),
    .in_boot    (in_boot)
`ifdef ARB_PERF_CNT_EN
    ,
    .perf_if_stall (perf_if_stall),
    .perf_dm_grant (perf_dm_grant)
`endif
  );

  // RAM model: one access per cycle, read data registered.
  logic [31:0] ram    [4096];
  bit          ram_ok [4096];

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we != 4'h0) begin : wr
        logic [31:0] w;
        w = ram_ok[mem_addr] ? ram[mem_addr] : (32'hA500_0000 | 32'(mem_addr));
        for (int b = 0; b < 4; b++) begin
          if (mem_we[b]) w[b*8 +: 8] = mem_wdata[b*8 +: 8];
        end
        ram[mem_addr]    <= w;
        ram_ok[mem_addr] <= 1'b1;
      end else begin
        mem_rdata <= ram_ok[mem_addr] ? ram[mem_addr] : (32'hA500_0000 | 32'(mem_addr));
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] lw [3];
  logic        exp_if;

  initial begin
    lw[0] = 32'hDEAD_BEEF;
    lw[1] = 32'h0123_4567;
    lw[2] = 32'hCAFE_F00D;
    reset = 1'b1; boot_done = 1'b0;
    ld_req = 1'b0; ld_addr = '0; ld_wdata = '0;
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_be = 4'h0; dm_addr = '0; dm_wdata = '0;

    // Reset state, with a loader request present that must not be granted
    tick();
    ld_req = 1'b1;
    tick();
    #3;
    check("rst_in_boot",    32'(in_boot),    32'd1);
    check("rst_stall",      32'(core_stall), 32'd1);
    check("rst_ld_gnt",     32'(ld_gnt),     32'd0);
    check("rst_mem_we",     32'(mem_we),     32'd0);
    check("rst_if_rvalid",  32'(if_rvalid),  32'd0);
    check("rst_dm_rvalid",  32'(dm_rvalid),  32'd0);
    check("rst_if_rdata",   if_rdata,        32'd0);
    check("rst_dm_rdata",   dm_rdata,        32'd0);

    // Boot load: three writes, boot_done with the last one; fetch held pending
    for (int i = 0; i < 3; i++) begin
      tick();
      reset = 1'b0;
      ld_req = 1'b1; ld_addr = AW'(i); ld_wdata = lw[i];
      if_req = 1'b1; if_addr = '0;
      boot_done = (i == 2);
      #3;
      check("boot_ld_gnt",  32'(ld_gnt),     32'd1);
      check("boot_mem_we",  32'(mem_we),     32'hF);
      check("boot_addr",    32'(mem_addr),   32'(i));
      check("boot_wdata",   mem_wdata,       lw[i]);
      check("boot_if_gnt",  32'(if_gnt),     32'd0);
      check("boot_stall",   32'(core_stall), 32'd1);
    end

    // First fetch in RUN returns the first loaded word
    tick();
    ld_req = 1'b0; boot_done = 1'b0; if_req = 1'b1; if_addr = '0;
    #3;
    check("run_in_boot", 32'(in_boot),    32'd0);
    check("run_if_gnt",  32'(if_gnt),     32'd1);
    check("run_ld_gnt",  32'(ld_gnt),     32'd0);
    check("run_stall",   32'(core_stall), 32'd0);
    tick();
    if_req = 1'b0;
    #3;
    check("run_if_rvalid", 32'(if_rvalid), 32'd1);
    check("run_if_rdata",  if_rdata,       32'hDEAD_BEEF);

    // Simultaneous fetch and load; boot_done in RUN must be ignored
    tick();
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 12'd5;
    if_req = 1'b1; if_addr = 12'd6; boot_done = 1'b1;
    #3;
    check("sim0_dm_gnt", 32'(dm_gnt),     32'd1);
    check("sim0_if_gnt", 32'(if_gnt),     32'd0);
    check("sim0_stall",  32'(core_stall), 32'd1);
    check("sim0_addr",   32'(mem_addr),   32'd5);
    tick();
    dm_req = 1'b0; boot_done = 1'b0;
    #3;
    check("sim1_dm_rvalid", 32'(dm_rvalid), 32'd1);
    check("sim1_dm_rdata",  dm_rdata,       32'hA500_0005);
    check("sim1_if_gnt",    32'(if_gnt),    32'd1);
    check("sim1_in_boot",   32'(in_boot),   32'd0);
    tick();
    if_req = 1'b0;
    #3;
    check("sim2_if_rvalid", 32'(if_rvalid), 32'd1);
    check("sim2_if_rdata",  if_rdata,       32'hA500_0006);
    check("sim2_dm_rvalid", 32'(dm_rvalid), 32'd0);
    check("sim2_dm_hold",   dm_rdata,       32'hA500_0005);

    // Byte store, then a zero-enable store, then read-back
    tick();
    dm_req = 1'b1; dm_we = 1'b1; dm_be = 4'b0010; dm_addr = 12'd9; dm_wdata = 32'hAABB_CCDD;
    #3;
    check("st_dm_gnt", 32'(dm_gnt), 32'd1);
    check("st_mem_we", 32'(mem_we), 32'h2);
    tick();
    dm_be = 4'b0000; dm_addr = 12'd10;
    #3;
    check("st_no_rvalid", 32'(dm_rvalid), 32'd0);
    check("st0_dm_gnt",   32'(dm_gnt),    32'd1);
    check("st0_mem_we",   32'(mem_we),    32'h0);
    tick();
    dm_we = 1'b0; dm_addr = 12'd9;
    #3;
    check("st0_no_rvalid", 32'(dm_rvalid), 32'd0);
    tick();
    dm_req = 1'b0;
    #3;
    check("st_rd_rvalid", 32'(dm_rvalid), 32'd1);
    check("st_rd_data",   dm_rdata,       32'hA500_CC09);

    // Reset in the cycle after a load grant
    tick();
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 12'd3;
    #3;
    check("mr_dm_gnt", 32'(dm_gnt), 32'd1);
    tick();
    reset = 1'b1; if_req = 1'b1;
    ld_req = 1'b1; ld_addr = 12'd20; ld_wdata = 32'h5555_AAAA;
    #3;
    check("mr_dm_rvalid", 32'(dm_rvalid), 32'd0);
    check("mr_in_boot",   32'(in_boot),   32'd1);
    check("mr_ld_gnt",    32'(ld_gnt),    32'd0);
    check("mr_if_gnt",    32'(if_gnt),    32'd0);
    check("mr_dm_gnt0",   32'(dm_gnt),    32'd0);
    tick();
    reset = 1'b0; dm_req = 1'b0; if_req = 1'b0;
    #3;
    check("mr_ld_again",   32'(ld_gnt),    32'd1);
    check("mr_no_rvalid",  32'(dm_rvalid), 32'd0);
    check("mr_dm_rdata0",  dm_rdata,       32'd0);
    check("mr_in_boot2",   32'(in_boot),   32'd1);

    // Starvation: data held for 10 cycles against a waiting fetch
    tick();
    ld_req = 1'b0; boot_done = 1'b1;
    #3;
    check("sv_boot_cycle", 32'(in_boot), 32'd1);
    for (int k = 0; k < 10; k++) begin
      tick();
      boot_done = 1'b0;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 12'd7;
      if_req = 1'b1; if_addr = 12'd8;
      #3;
      exp_if = (k == 4) || (k == 9);
      check("sv_if_gnt", 32'(if_gnt),     32'(exp_if));
      check("sv_dm_gnt", 32'(dm_gnt),     32'(!exp_if));
      check("sv_stall",  32'(core_stall), 32'd1);
      if (k == 5) begin
        check("sv_if_rvalid", 32'(if_rvalid), 32'd1);
        check("sv_if_rdata",  if_rdata,       32'hA500_0008);
      end
    end
    tick();
    dm_req = 1'b0; if_req = 1'b0;
    #3;
    check("sv_last_if_rvalid", 32'(if_rvalid), 32'd1);
`ifdef ARB_PERF_CNT_EN
    check("perf_if_stall", perf_if_stall, 32'd8);
    check("perf_dm_grant", perf_dm_grant, 32'd8);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
